// File: rtl/cnn_conv_mac_ctrl.sv
// Sequencer and multiply-accumulate datapath for one convolution output pixel:
// walks N_TAPS feature/weight pairs, accumulates onto a bias, then shifts and saturates.
module cnn_conv_mac_ctrl #(
  parameter int N_TAPS = 9,
  parameter int ACC_W  = 26,
  parameter int SHIFT  = 0,
  parameter int OUT_W  = 16,
  localparam int AW    = (N_TAPS > 1) ? $clog2(N_TAPS) : 1
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    ap_start,
  output logic                    ap_done,
  output logic                    ap_idle,
  output logic                    ap_ready,
  input  logic signed [ACC_W-1:0] bias,
  output logic [AW-1:0]           rd_addr,
  output logic                    rd_ce,
  input  logic signed [13:0]      feat_q,
  input  logic signed [7:0]       wgt_q,
  output logic signed [OUT_W-1:0] result
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  localparam logic [AW-1:0] LAST_TAP = AW'(N_TAPS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

  state_e                  state_q;
  logic [AW-1:0]           cnt_q;
  logic [AW-1:0]           rd_addr_q;
  logic                    rd_ce_q;
  logic                    data_vld_q;
  logic                    prod_vld_q;
  logic                    ap_done_q;
  logic                    ap_ready_q;
  logic                    ap_idle_q;
  logic signed [21:0]      prod_q;
  logic signed [21:0]      prod_d;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] shifted;
  logic signed [OUT_W-1:0] sat_d;
  logic signed [OUT_W-1:0] result_q;

  // Only a valid product may touch the accumulator; sum wraps at ACC_W bits.
  always_comb begin
    prod_d = feat_q * wgt_q;
    acc_d  = acc_q;
    if (prod_vld_q) begin
      acc_d = acc_q + ACC_W'(prod_q);
    end
    shifted = acc_d >>> SHIFT;
    sat_d   = shifted[OUT_W-1:0];
    if (shifted > SAT_MAX) begin
      sat_d = SAT_MAX[OUT_W-1:0];
    end else if (shifted < SAT_MIN) begin
      sat_d = SAT_MIN[OUT_W-1:0];
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rd_addr_q  <= '0;
      rd_ce_q    <= 1'b0;
      data_vld_q <= 1'b0;
      prod_vld_q <= 1'b0;
      ap_done_q  <= 1'b0;
      ap_ready_q <= 1'b0;
      ap_idle_q  <= 1'b1;
      prod_q     <= '0;
      acc_q      <= '0;
      result_q   <= '0;
    end else begin
      data_vld_q <= rd_ce_q;
      prod_vld_q <= data_vld_q;
      if (data_vld_q) begin
        prod_q <= prod_d;
      end
      acc_q      <= acc_d;
      ap_done_q  <= 1'b0;
      ap_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ap_start) begin
            state_q    <= RUN;
            acc_q      <= bias;
            cnt_q      <= '0;
            rd_ce_q    <= 1'b1;
            rd_addr_q  <= '0;
            ap_idle_q  <= 1'b0;
            ap_ready_q <= (N_TAPS == 1);
          end
        end
        RUN: begin
          if (cnt_q == LAST_TAP) begin
            state_q   <= DRAIN;
            rd_ce_q   <= 1'b0;
            rd_addr_q <= '0;
          end else begin
            cnt_q      <= cnt_q + AW'(1);
            rd_addr_q  <= cnt_q + AW'(1);
            // ready must coincide with the cycle the last address is on the bus
            ap_ready_q <= (int'(cnt_q) == N_TAPS - 2);
          end
        end
        DRAIN: begin
          if (!data_vld_q && prod_vld_q) begin
            state_q   <= DONE;
            result_q  <= sat_d;
            ap_done_q <= 1'b1;
          end
        end
        DONE: begin
          state_q   <= IDLE;
          ap_idle_q <= 1'b1;
        end
        default: begin
          state_q   <= IDLE;
          ap_idle_q <= 1'b1;
        end
      endcase
    end
  end

  assign ap_done  = ap_done_q;
  assign ap_idle  = ap_idle_q;
  assign ap_ready = ap_ready_q;
  assign rd_addr  = rd_addr_q;
  assign rd_ce    = rd_ce_q;
  assign result   = result_q;

endmodule

// File: tb/tb_cnn_conv_mac_ctrl.sv
// Bench for cnn_conv_mac_ctrl: vector table, random runs against an arithmetic
// model, back-to-back starts and mid-run reset. A SHIFT=4 twin shares all inputs.
module tb_cnn_conv_mac_ctrl;

  localparam int N = 9;

  typedef struct {
    logic signed [13:0] feat [N];
    logic signed [7:0]  wgt  [N];
    logic signed [25:0] bias;
    logic signed [15:0] expRes;
    logic signed [15:0] expRes4;
    bit                 poke;
  } vec_t;

  logic               clk = 1'b0;
  logic               rstN;
  logic               start;
  logic signed [25:0] bias;
  logic signed [13:0] featQ;
  logic signed [7:0]  wgtQ;

  logic               done, idle, ready, rdCe;
  logic [3:0]         rdAddr;
  logic signed [15:0] result;
  logic               done4, idle4, ready4, rdCe4;
  logic [3:0]         rdAddr4;
  logic signed [15:0] result4;

  logic signed [13:0] featMem [N];
  logic signed [7:0]  wgtMem  [N];

  int compared   = 0;
  int mismatched = 0;

  vec_t vecs [7];

  cnn_conv_mac_ctrl dut (
    .ap_clk(clk), .ap_rst_n(rstN), .ap_start(start),
    .ap_done(done), .ap_idle(idle), .ap_ready(ready),
    .bias(bias), .rd_addr(rdAddr), .rd_ce(rdCe),
    .feat_q(featQ), .wgt_q(wgtQ), .result(result)
  );

  cnn_conv_mac_ctrl #(.SHIFT(4)) dut4 (
    .ap_clk(clk), .ap_rst_n(rstN), .ap_start(start),
    .ap_done(done4), .ap_idle(idle4), .ap_ready(ready4),
    .bias(bias), .rd_addr(rdAddr4), .rd_ce(rdCe4),
    .feat_q(featQ), .wgt_q(wgtQ), .result(result4)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories; garbage on idle cycles exposes ungated accumulation.
  always @(posedge clk) begin
    if (rdCe) begin
      featQ <= featMem[rdAddr];
      wgtQ  <= wgtMem[rdAddr];
    end else begin
      featQ <= 14'($urandom);
      wgtQ  <= 8'($urandom);
    end
  end

  function automatic logic signed [15:0] refResult(input int shiftAmt);
    longint             sum;
    logic signed [25:0] wrapped;
    longint             v;
    sum = longint'(bias);
    for (int k = 0; k < N; k++) begin
      sum += longint'(featMem[k]) * longint'(wgtMem[k]);
    end
    wrapped = 26'(sum);
    v = longint'(wrapped) >>> shiftAmt;
    if (v > 32767) v = 32767;
    else if (v < -32768) v = -32768;
    return 16'(v);
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One start pulse at cycle 0, observed through cycle 14.
  task automatic runOne(input string tag, input logic signed [15:0] expRes,
                        input logic signed [15:0] expRes4, input bit poke);
    int readyCyc = -1, readyCnt = 0, doneCyc = -1, doneCnt = 0;
    int ceCnt = 0, addrErr = 0, twinErr = 0, idleAt13 = 0;
    logic signed [15:0] resAtDone = '0, res4AtDone = '0;
    @(negedge clk);
    checkOutput({tag, " idle before start"}, idle, 1);
    start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (rdCe) begin
        ceCnt++;
        if (int'(rdAddr) != c - 1) addrErr++;
      end else if (rdAddr != 4'd0) begin
        addrErr++;
      end
      if ({done4, idle4, ready4, rdCe4, rdAddr4} != {done, idle, ready, rdCe, rdAddr}) twinErr++;
      if (ready) begin readyCnt++; readyCyc = c; end
      if (done) begin doneCnt++; doneCyc = c; resAtDone = result; res4AtDone = result4; end
      if (c == 13) idleAt13 = int'(idle);
      start = poke && (c inside {3, 5, 7, 11, 12});
    end
    checkOutput({tag, " rd_ce cycles"}, ceCnt, N);
    checkOutput({tag, " addr errors"}, addrErr, 0);
    checkOutput({tag, " twin handshake errors"}, twinErr, 0);
    checkOutput({tag, " ready count"}, readyCnt, 1);
    checkOutput({tag, " ready cycle"}, readyCyc, 9);
    checkOutput({tag, " done count"}, doneCnt, 1);
    checkOutput({tag, " done cycle"}, doneCyc, 12);
    checkOutput({tag, " idle at 13"}, idleAt13, 1);
    checkOutput({tag, " result"}, resAtDone, expRes);
    checkOutput({tag, " result shift4"}, res4AtDone, expRes4);
    checkOutput({tag, " result held"}, result, expRes);
  endtask

  task automatic applyStimulus(input vec_t v);
    for (int k = 0; k < N; k++) begin
      featMem[k] = v.feat[k];
      wgtMem[k]  = v.wgt[k];
    end
    bias = v.bias;
  endtask

  task automatic fillVec(output vec_t v, input int f, input int w, input int b,
                         input int e, input int e4, input bit poke);
    for (int k = 0; k < N; k++) begin
      v.feat[k] = 14'(f);
      v.wgt[k]  = 8'(w);
    end
    v.bias = 26'(b); v.expRes = 16'(e); v.expRes4 = 16'(e4); v.poke = poke;
  endtask

  initial begin
    int doneQ [$];
    int idleQ [$];
    int goodRes;
    int sawDone;

    fillVec(vecs[0], 1, 1, 0, 9, 0, 1'b0);
    fillVec(vecs[1], -8192, -128, 0, 32767, 32767, 1'b0);
    fillVec(vecs[2], -8192, 127, 0, -32768, -32768, 1'b0);
    fillVec(vecs[3], 0, -1, 100, 64, 4, 1'b1);
    for (int k = 0; k < N; k++) vecs[3].feat[k] = 14'(k);
    fillVec(vecs[4], 0, 0, -17, -17, -2, 1'b0);
    fillVec(vecs[5], 1, 1, 33554431, -32768, -32768, 1'b0);
    fillVec(vecs[6], 100, -3, 50, -2650, -166, 1'b0);

    rstN = 1'b0; start = 1'b0; bias = '0;
    for (int k = 0; k < N; k++) begin featMem[k] = '0; wgtMem[k] = '0; end
    repeat (3) @(negedge clk);
    checkOutput("reset idle", idle, 1);
    checkOutput("reset done/ready/ce", {done, ready, rdCe}, 0);
    checkOutput("reset rd_addr", rdAddr, 0);
    checkOutput("reset result", result, 0);
    rstN = 1'b1;

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
      runOne($sformatf("vec%0d", i), vecs[i].expRes, vecs[i].expRes4, vecs[i].poke);
    end

    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < N; k++) begin
        featMem[k] = 14'($urandom);
        wgtMem[k]  = 8'($urandom);
      end
      bias = (i < 4) ? 26'($urandom) : 26'($urandom_range(0, 4000)) - 26'sd2000;
      runOne($sformatf("rand%0d", i), refResult(0), refResult(4), 1'b0);
    end

    // Start held high across three back-to-back runs.
    for (int k = 0; k < N; k++) begin featMem[k] = 14'sd2; wgtMem[k] = 8'sd3; end
    bias = 26'sd1;
    goodRes = 0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) begin
        doneQ.push_back(c);
        if (result == 16'sd55 && result4 == 16'sd3) goodRes++;
      end
      if (idle && c <= 38) idleQ.push_back(c);
      if (c >= 27) start = 1'b0;
    end
    checkOutput("b2b done count", doneQ.size(), 3);
    checkOutput("b2b done 1", (doneQ.size() > 0) ? doneQ[0] : -1, 12);
    checkOutput("b2b done 2", (doneQ.size() > 1) ? doneQ[1] : -1, 25);
    checkOutput("b2b done 3", (doneQ.size() > 2) ? doneQ[2] : -1, 38);
    checkOutput("b2b idle count", idleQ.size(), 2);
    checkOutput("b2b idle 1", (idleQ.size() > 0) ? idleQ[0] : -1, 13);
    checkOutput("b2b idle 2", (idleQ.size() > 1) ? idleQ[1] : -1, 26);
    checkOutput("b2b results", goodRes, 3);

    // Reset dropped at cycle 5 of a run.
    applyStimulus(vecs[3]);
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rstN = 1'b0;
    #1;
    checkOutput("midrst idle", idle, 1);
    checkOutput("midrst done/ready/ce", {done, ready, rdCe}, 0);
    checkOutput("midrst rd_addr", rdAddr, 0);
    checkOutput("midrst result", result, 0);
    checkOutput("midrst result shift4", result4, 0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    sawDone = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done || done4 || rdCe) sawDone++;
    end
    checkOutput("midrst no activity", sawDone, 0);
    applyStimulus(vecs[0]);
    runOne("restart", vecs[0].expRes, vecs[0].expRes4, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cnn_conv_mac_ctrl.md
CNN_CONV_MAC_CTRL -- requirements
Module: cnn_conv_mac_ctrl

Interface
REQ-001 SHALL have parameter N_TAPS, default 9, meaning taps per output (3x3 kernel).
REQ-002 SHALL have parameter ACC_W, default 26, meaning accumulator width in bits (two's complement).
REQ-003 SHALL have parameter SHIFT, default 0, meaning arithmetic right shift applied to the accumulator before output saturation.
REQ-004 SHALL have parameter OUT_W, default 16, meaning result width in bits.
REQ-005 SHALL have port ap_clk, input, 1: the single clock; all logic on rising edge.
REQ-006 SHALL have port ap_rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-007 SHALL have port ap_start, input, 1: start request, level-sampled in IDLE.
REQ-008 SHALL have port ap_done, output, 1: one-cycle pulse, result valid.
REQ-009 SHALL have port ap_idle, output, 1: high while in IDLE.
REQ-010 SHALL have port ap_ready, output, 1: one-cycle pulse, last tap address issued.
REQ-011 SHALL have port bias, input, ACC_W: accumulator initial value, sampled at start.
REQ-012 SHALL have port rd_addr, output, clog2(N_TAPS): tap index for both feature and weight memories.
REQ-013 SHALL have port rd_ce, output, 1: memory read enable.
REQ-014 SHALL have port feat_q, input, 14 signed: feature data, valid one cycle after rd_ce.
REQ-015 SHALL have port wgt_q, input, 8 signed: weight data, valid one cycle after rd_ce.
REQ-016 SHALL have port result, output, OUT_W signed: saturated output, held until next ap_done.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-018 IDLE SHALL go to RUN when ap_start=1, loading acc<=bias and tap counter<=0; ap_start SHALL be ignored in all other states.
REQ-019 RUN SHALL drive rd_ce=1 and rd_addr=counter each cycle, incrementing the counter; after issuing index N_TAPS-1 it SHALL pulse ap_ready and go to DRAIN.
REQ-020 The 14sx8s product (22-bit signed) of feat_q and wgt_q SHALL be registered one cycle after data arrives, and sign-extended to ACC_W and added to acc on the following cycle.
REQ-021 A valid-bit pipeline (ce->data->product) SHALL gate accumulation; exactly N_TAPS products SHALL be added per run.
REQ-022 DRAIN SHALL hold rd_ce=0 until the last product is accumulated, then go to DONE.
REQ-023 DONE SHALL pulse ap_done for one cycle, update result, and go to IDLE unconditionally.
REQ-024 Accumulation SHALL wrap modulo 2^ACC_W; no internal saturation.
REQ-025 result SHALL be (acc >>> SHIFT) clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-026 With start accepted in cycle 0: addresses SHALL be issued in cycles 1..N_TAPS, ap_ready in cycle N_TAPS, and ap_done in cycle N_TAPS+3 (cycle 12 for default).
REQ-027 With ap_start held high, runs SHALL repeat with period N_TAPS+4 cycles.
REQ-028 rd_addr SHALL be 0 whenever rd_ce=0.

Reset
REQ-029 When ap_rst_n=0, the block SHALL immediately enter IDLE with: ap_idle=1; ap_done, ap_ready and rd_ce at 0; rd_addr, result, acc, counter and valid bits at 0.
REQ-030 Reset mid-run SHALL abort the run: no ap_done, result=0, and the first start after release SHALL behave as from power-up.

Verification
REQ-031 feat_q=1, wgt_q=1, bias=0, start pulse at cycle 0 -> ap_ready at cycle 9, ap_done at cycle 12, result=9.
REQ-032 feat_q=-8192, wgt_q=-128, bias=0 -> acc=9437184, result=32767 (saturated high); with wgt_q=127 -> result=-32768.
REQ-033 feat_q=tap index k, wgt_q=-1, bias=100 -> result=64; ap_start pulses during RUN -> ignored.
REQ-034 ap_start held high for 3 runs -> ap_done at cycles 12, 25, 38; ap_idle high only at cycles 13 and 26.
REQ-035 ap_rst_n low at cycle 5 of a run -> outputs at reset values at once, no ap_done; a restart gives correct result and timing.
REQ-036 SHIFT=4, bias=-17, all products 0 -> result=-2 (arithmetic shift, floor).
